// File: rtl/instruction_queue_if.sv
// Fetch-to-decode instruction queue bus: push side, pop side, flush and occupancy.
// Latency: not applicable (signal bundle only).
// Backpressure: in_ready throttles fetch; out_valid/out_ready gate decode.
interface instruction_queue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] instruction_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] instruction_out;
  logic [CNT_W-1:0] count;

  // Fetch/decode side that drives the queue.
  modport master (
    output flush,
    output in_valid,
    output instruction_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  instruction_out,
    input  count
  );

  // The queue itself.
  modport slave (
    input  flush,
    input  in_valid,
    input  instruction_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output instruction_out,
    output count
  );
endinterface

// File: rtl/instruction_queue.sv
// DEPTH-entry first-word-fall-through FIFO between instruction fetch and decode.
// Latency: 1 cycle from push into an empty queue to out_valid; no same-cycle bypass.
// Backpressure: in_ready drops when full (no full pass-through); flush discards everything.
module instruction_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  instruction_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             in_ready_w;
  logic             out_valid_w;
  logic             push;
  logic             pop;

  // Flags come straight from the occupancy count, so a pop while full only
  // re-opens in_ready on the following cycle.
  assign in_ready_w  = (count_q < CNT_W'(DEPTH));
  assign out_valid_w = (count_q != '0);

  // Flush wins over both handshakes in the same cycle.
  assign push = bus.in_valid && in_ready_w && !bus.flush;
  assign pop  = out_valid_w && bus.out_ready && !bus.flush;

  assign bus.in_ready        = in_ready_w;
  assign bus.out_valid       = out_valid_w;
  assign bus.instruction_out = out_valid_w ? mem[rd_ptr] : '0;
  assign bus.count           = count_q;

  // Storage write on accepted push; cleared only by reset, flush leaves stale data
  // that is masked by out_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= bus.instruction_in;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two DEPTH makes the pointers
  // wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: vector table, hand sequences, random vs queue model.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: exercised through full, empty, flush and simultaneous push/pop cases.
module tb_instruction_queue;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  instruction_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) qif ();

  instruction_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (qif)
  );

  typedef struct {
    logic        iv;
    logic [15:0] din;
    logic        ordy;
    logic        fl;
    int          exp_cnt;
    logic        exp_ov;
    logic [15:0] exp_out;
    logic        exp_ir;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] model_q[$];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [15:0] din, input logic ordy, input logic fl);
    qif.in_valid       = iv;
    qif.instruction_in = din;
    qif.out_ready      = ordy;
    qif.flush          = fl;
  endtask

  task automatic check_all(input string tag, input int cnt, input logic ov,
                           input logic [15:0] dout, input logic ir);
    chk({tag, ".count"},     32'(qif.count),     32'(cnt));
    chk({tag, ".out_valid"}, 32'(qif.out_valid), 32'(ov));
    chk({tag, ".instr_out"}, 32'(qif.instruction_out), 32'(dout));
    chk({tag, ".in_ready"},  32'(qif.in_ready),  32'(ir));
  endtask

  task automatic addv(input logic iv, input logic [15:0] din, input logic ordy, input logic fl,
                      input int cnt, input logic ov, input logic [15:0] dout, input logic ir);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
    v.exp_cnt = cnt; v.exp_ov = ov; v.exp_out = dout; v.exp_ir = ir;
    vecs.push_back(v);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Reset held for two cycles, then released.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_held", 0, 1'b0, 16'h0000, 1'b1);
    reset = 1'b1;
    cyc();
    check_all("reset_released", 0, 1'b0, 16'h0000, 1'b1);

    // Vector table: inputs applied before an edge, expectations after it.
    // FWFT single entry, then hold.
    addv(1'b1, 16'h00CC, 1'b0, 1'b0, 1, 1'b1, 16'h00CC, 1'b1);
    addv(1'b0, 16'h1111, 1'b0, 1'b0, 1, 1'b1, 16'h00CC, 1'b1);
    addv(1'b0, 16'h2222, 1'b0, 1'b0, 1, 1'b1, 16'h00CC, 1'b1);
    addv(1'b0, 16'h3333, 1'b0, 1'b0, 1, 1'b1, 16'h00CC, 1'b1);
    addv(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b1);
    // Fill to full, reject a push while full, drain in order.
    addv(1'b1, 16'h0001, 1'b0, 1'b0, 1, 1'b1, 16'h0001, 1'b1);
    addv(1'b1, 16'h0002, 1'b0, 1'b0, 2, 1'b1, 16'h0001, 1'b1);
    addv(1'b1, 16'h0003, 1'b0, 1'b0, 3, 1'b1, 16'h0001, 1'b1);
    addv(1'b1, 16'h0004, 1'b0, 1'b0, 4, 1'b1, 16'h0001, 1'b0);
    addv(1'b1, 16'h0005, 1'b0, 1'b0, 4, 1'b1, 16'h0001, 1'b0);
    addv(1'b0, 16'h0000, 1'b1, 1'b0, 3, 1'b1, 16'h0002, 1'b1);
    addv(1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b1, 16'h0003, 1'b1);
    addv(1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b1, 16'h0004, 1'b1);
    addv(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b1);
    addv(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b1);
    // Full with push+pop: pop honoured, push ignored.
    addv(1'b1, 16'h00A1, 1'b0, 1'b0, 1, 1'b1, 16'h00A1, 1'b1);
    addv(1'b1, 16'h00A2, 1'b0, 1'b0, 2, 1'b1, 16'h00A1, 1'b1);
    addv(1'b1, 16'h00A3, 1'b0, 1'b0, 3, 1'b1, 16'h00A1, 1'b1);
    addv(1'b1, 16'h00A4, 1'b0, 1'b0, 4, 1'b1, 16'h00A1, 1'b0);
    addv(1'b1, 16'h0055, 1'b1, 1'b0, 3, 1'b1, 16'h00A2, 1'b1);
    // Flush with 3 entries queued, simultaneous push and pop.
    addv(1'b1, 16'h00F0, 1'b1, 1'b1, 0, 1'b0, 16'h0000, 1'b1);
    addv(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
      cyc();
      check_all($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_ov,
                vecs[i].exp_out, vecs[i].exp_ir);
    end

    // Streaming at count=2 across pointer wrap.
    drive(1'b1, 16'h0100, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 16'h0101, 1'b0, 1'b0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(16'h0102 + i), 1'b1, 1'b0);
      cyc();
      chk($sformatf("stream%0d.count", i), 32'(qif.count), 32'd2);
      chk($sformatf("stream%0d.instr_out", i), 32'(qif.instruction_out), 32'(16'h0101 + i));
    end
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    cyc();
    check_all("stream_flush", 0, 1'b0, 16'h0000, 1'b1);

    // Asynchronous reset between edges with 3 entries queued.
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(16'h0B00 + i), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("pre_async.count", 32'(qif.count), 32'd3);
    #3;
    reset = 1'b0;
    #1;
    check_all("async_reset", 0, 1'b0, 16'h0000, 1'b1);
    #1;
    reset = 1'b1;
    cyc();
    check_all("after_async", 0, 1'b0, 16'h0000, 1'b1);

    // Randomized traffic against a queue model.
    model_q.delete();
    for (int i = 0; i < 400; i++) begin
      logic        iv;
      logic        ordy;
      logic        fl;
      logic [15:0] din;
      logic        can_push;
      logic        can_pop;
      iv   = 1'($urandom_range(0, 99) < 60);
      ordy = 1'($urandom_range(0, 99) < 50);
      fl   = 1'($urandom_range(0, 99) < 4);
      din  = 16'($urandom);
      chk($sformatf("rnd%0d.count", i), 32'(qif.count), 32'(model_q.size()));
      chk($sformatf("rnd%0d.out_valid", i), 32'(qif.out_valid), 32'(model_q.size() != 0));
      chk($sformatf("rnd%0d.in_ready", i), 32'(qif.in_ready), 32'(model_q.size() < DEPTH));
      chk($sformatf("rnd%0d.instr_out", i), 32'(qif.instruction_out),
          32'((model_q.size() != 0) ? model_q[0] : 16'h0000));
      drive(iv, din, ordy, fl);
      can_push = iv && (model_q.size() < DEPTH);
      can_pop  = ordy && (model_q.size() != 0);
      if (fl) begin
        model_q.delete();
      end else begin
        if (can_pop) void'(model_q.pop_front());
        if (can_push) model_q.push_back(din);
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
